// File: rtl/beat_sequencer_if.sv
// Song ROM fetch port and step-row output of the beat sequencer.
// Latency: rom_data is valid one cycle after rom_addr; step_out/step_en are registered by the sequencer.
// Backpressure: none; the shift register must accept step_out on every step_en pulse.
interface beat_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] rom_addr;
  logic [4:0]        rom_data;
  logic [3:0]        step_out;
  logic              step_en;

  modport master (
    output rom_addr,
    output step_out,
    output step_en,
    input  rom_data
  );

  modport slave (
    input  rom_addr,
    input  step_out,
    input  step_en,
    output rom_data
  );
endinterface

// File: rtl/beat_sequencer.sv
// Game-flow scheduler: beat divider, song ROM prefetch, idle/countdown/play/pause/drain/done sequencing.
// Latency: first step_en exactly P cycles after an accepted start, then one pulse every P running cycles.
// Backpressure: none; pause_toggle freezes the divider and all song progress until toggled again.
module beat_sequencer #(
  parameter int ADDR_W          = 8,
  parameter int DIV_W           = 24,
  parameter int COUNTDOWN_BEATS = 4,
  parameter int DRAIN_BEATS     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pause_toggle,
  input  logic [DIV_W-1:0]  beat_period,
  beat_sequencer_if.master  bus,
  output logic [2:0]        state,
  output logic [2:0]        countdown,
  output logic [ADDR_W-1:0] beat_count,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_PLAY      = 3'd2,
    S_PAUSE     = 3'd3,
    S_DRAIN     = 3'd4,
    S_DONE      = 3'd5
  } state_e;

  localparam int DRAIN_W = $clog2(DRAIN_BEATS + 1);

  state_e              state_q, state_d;
  state_e              saved_q, saved_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [DIV_W-1:0]    period_q, period_d;
  logic [2:0]          countdown_q, countdown_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0]   beat_count_q, beat_count_d;
  logic [4:0]          next_word_q, next_word_d;
  logic [3:0]          step_out_q, step_out_d;
  logic                step_en_q, step_en_d;
  logic                done_q, done_d;
  logic                tick;

  // Divider reaches its last count: this cycle's edge produces a beat.
  assign tick = (div_q == period_q - DIV_W'(1));

  // Next-state and datapath updates for the whole game flow.
  always_comb begin
    state_d      = state_q;
    saved_d      = saved_q;
    div_d        = div_q;
    period_d     = period_q;
    countdown_d  = countdown_q;
    drain_d      = drain_q;
    rom_addr_d   = rom_addr_q;
    beat_count_d = beat_count_q;
    step_out_d   = step_out_q;
    step_en_d    = 1'b0;
    done_d       = done_q;
    // The ROM address is held for several cycles, so sampling every cycle
    // leaves next_word valid one cycle after any address change.
    next_word_d  = bus.rom_data;

    case (state_q)
      S_IDLE, S_DONE: begin
        // start beats a coincident pause_toggle here; pause is simply not looked at.
        if (start) begin
          period_d     = (beat_period < DIV_W'(2)) ? DIV_W'(2) : beat_period;
          div_d        = '0;
          countdown_d  = 3'(COUNTDOWN_BEATS);
          beat_count_d = '0;
          rom_addr_d   = '0;
          step_out_d   = 4'd0;
          done_d       = 1'b0;
          state_d      = S_COUNTDOWN;
        end
      end

      S_COUNTDOWN, S_PLAY, S_DRAIN: begin
        div_d = tick ? '0 : div_q + DIV_W'(1);
        if (tick) begin
          step_en_d = 1'b1;
          case (state_q)
            S_COUNTDOWN: begin
              step_out_d  = 4'd0;
              countdown_d = countdown_q - 3'd1;
              if (countdown_q <= 3'd1) begin
                countdown_d = 3'd0;
                state_d     = S_PLAY;
              end
            end
            S_PLAY: begin
              step_out_d = next_word_q[3:0];
              if (beat_count_q != {ADDR_W{1'b1}}) begin
                beat_count_d = beat_count_q + ADDR_W'(1);
              end
              // Last row: explicit end flag, or the top of the ROM (no wrap).
              if (next_word_q[4] || (rom_addr_q == {ADDR_W{1'b1}})) begin
                drain_d = DRAIN_W'(DRAIN_BEATS);
                state_d = S_DRAIN;
              end else begin
                rom_addr_d = rom_addr_q + ADDR_W'(1);
              end
            end
            default: begin
              step_out_d = 4'd0;
              drain_d    = drain_q - DRAIN_W'(1);
              if (drain_q <= DRAIN_W'(1)) begin
                done_d  = 1'b1;
                state_d = S_DONE;
              end
            end
          endcase
        end
        // The tick (if any) has already been applied; remember the state it
        // left us in. A song that just finished is not paused.
        if (pause_toggle && (state_d != S_DONE)) begin
          saved_d = state_d;
          state_d = S_PAUSE;
        end
      end

      S_PAUSE: begin
        if (pause_toggle) begin
          state_d = saved_q;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and all outputs registered; synchronous reset aborts any song.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      saved_q      <= S_IDLE;
      div_q        <= '0;
      period_q     <= DIV_W'(2);
      countdown_q  <= 3'd0;
      drain_q      <= '0;
      rom_addr_q   <= '0;
      beat_count_q <= '0;
      next_word_q  <= 5'd0;
      step_out_q   <= 4'd0;
      step_en_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      saved_q      <= saved_d;
      div_q        <= div_d;
      period_q     <= period_d;
      countdown_q  <= countdown_d;
      drain_q      <= drain_d;
      rom_addr_q   <= rom_addr_d;
      beat_count_q <= beat_count_d;
      next_word_q  <= next_word_d;
      step_out_q   <= step_out_d;
      step_en_q    <= step_en_d;
      done_q       <= done_d;
    end
  end

  assign bus.rom_addr = rom_addr_q;
  assign bus.step_out = step_out_q;
  assign bus.step_en  = step_en_q;
  assign state        = state_q;
  assign countdown    = countdown_q;
  assign beat_count   = beat_count_q;
  assign done         = done_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// Directed bench for beat_sequencer: a full-size song DUT and a 3-bit-address DUT without end flags.
// Latency: outputs sampled 1 time unit after each falling edge, inputs driven there too.
// Backpressure: not applicable; every beat pulse is recorded with its cycle number and row.
module tb_beat_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        pause_toggle;
  logic [23:0] beat_period;

  logic [2:0]  state_a, cd_a, state_b, cd_b;
  logic [7:0]  bc_a;
  logic [2:0]  bc_b;
  logic        done_a, done_b;

  logic [4:0]  rom_a [256];
  logic [4:0]  rom_b [8];
  logic [3:0]  exp_a [15];
  logic [3:0]  exp_b [12];

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          dbl_cnt = 0;
  logic        prev_en_a = 1'b0;
  logic        prev_en_b = 1'b0;
  int          pa_cyc [$];
  logic [3:0]  pa_val [$];
  logic [3:0]  pb_val [$];

  beat_sequencer_if #(.ADDR_W(8)) ifa ();
  beat_sequencer_if #(.ADDR_W(3)) ifb ();

  assign ifa.rom_data = rom_a[ifa.rom_addr];
  assign ifb.rom_data = rom_b[ifb.rom_addr];

  beat_sequencer #(.ADDR_W(8), .DIV_W(24), .COUNTDOWN_BEATS(4), .DRAIN_BEATS(8)) dut_a (
    .clk(clk), .reset(reset), .start(start), .pause_toggle(pause_toggle),
    .beat_period(beat_period), .bus(ifa),
    .state(state_a), .countdown(cd_a), .beat_count(bc_a), .done(done_a)
  );

  beat_sequencer #(.ADDR_W(3), .DIV_W(24), .COUNTDOWN_BEATS(4), .DRAIN_BEATS(8)) dut_b (
    .clk(clk), .reset(reset), .start(start), .pause_toggle(pause_toggle),
    .beat_period(beat_period), .bus(ifb),
    .state(state_b), .countdown(cd_b), .beat_count(bc_b), .done(done_b)
  );

  always #5 clk = ~clk;

  // Cycle counter advanced on every active edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Beat recorder and back-to-back step_en detector.
  always @(negedge clk) begin
    if (ifa.step_en) begin
      pa_cyc.push_back(cyc);
      pa_val.push_back(ifa.step_out);
    end
    if (ifb.step_en) pb_val.push_back(ifb.step_out);
    if ((ifa.step_en && prev_en_a) || (ifb.step_en && prev_en_b)) dbl_cnt++;
    prev_en_a = ifa.step_en;
    prev_en_b = ifb.step_en;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_start(input logic [23:0] p, input logic with_pause, output int t0);
    beat_period  = p;
    start        = 1'b1;
    pause_toggle = with_pause;
    step();
    start        = 1'b0;
    pause_toggle = 1'b0;
    t0           = cyc;
  endtask

  task automatic wait_a_done(input string tag);
    int n;
    n = 0;
    while (!done_a && n < 1000) begin
      step();
      n++;
    end
    check_val(tag, 32'(done_a), 32'd1);
  endtask

  task automatic check_song(input string tag, input int t0, input int p, input int skip);
    int bad_iv;
    int bad_val;
    bad_iv  = 0;
    bad_val = 0;
    check_val({tag, "_npulse"}, 32'(pa_cyc.size()), 32'd15);
    if (pa_cyc.size() > 0) check_val({tag, "_first_gap"}, 32'(pa_cyc[0] - t0), 32'(p));
    for (int i = 0; i + 1 < pa_cyc.size(); i++)
      if (i != skip && (pa_cyc[i+1] - pa_cyc[i]) != p) bad_iv++;
    for (int i = 0; i < pa_val.size() && i < 15; i++)
      if (pa_val[i] !== exp_a[i]) bad_val++;
    check_val({tag, "_bad_intervals"}, 32'(bad_iv), 32'd0);
    check_val({tag, "_bad_rows"}, 32'(bad_val), 32'd0);
    check_val({tag, "_beat_count"}, 32'(bc_a), 32'd3);
    check_val({tag, "_state_done"}, 32'(state_a), 32'd5);
    check_val({tag, "_step_out"}, 32'(ifa.step_out), 32'd0);
  endtask

  initial begin
    int t0;
    int t_res;
    int n;
    int bad;
    int n_before;

    foreach (rom_a[i]) rom_a[i] = 5'd0;
    rom_a[0] = 5'h01;
    rom_a[1] = 5'h02;
    rom_a[2] = 5'h14;
    foreach (rom_b[i]) rom_b[i] = 5'(i + 1);
    foreach (exp_a[i]) exp_a[i] = 4'd0;
    exp_a[4] = 4'h1;
    exp_a[5] = 4'h2;
    exp_a[6] = 4'h4;
    foreach (exp_b[i]) exp_b[i] = (i < 4) ? 4'd0 : 4'(i - 3);

    reset        = 1'b1;
    start        = 1'b0;
    pause_toggle = 1'b0;
    beat_period  = 24'd0;
    repeat (3) step();
    reset = 1'b0;

    // Idle after reset: nothing moves for 100 cycles.
    bad = 0;
    repeat (100) begin
      step();
      if (state_a != 3'd0 || ifa.step_en) bad++;
    end
    check_val("idle_activity", 32'(bad), 32'd0);
    check_val("idle_pulses", 32'(pa_cyc.size()), 32'd0);
    check_val("idle_state", 32'(state_a), 32'd0);
    check_val("idle_rom_addr", 32'(ifa.rom_addr), 32'd0);
    check_val("idle_step_out", 32'(ifa.step_out), 32'd0);
    check_val("idle_countdown", 32'(cd_a), 32'd0);
    check_val("idle_beat_count", 32'(bc_a), 32'd0);
    check_val("idle_done", 32'(done_a), 32'd0);

    // Basic song at P=4.
    pa_cyc.delete();
    pa_val.delete();
    do_start(24'd4, 1'b0, t0);
    check_val("basic_state_cd", 32'(state_a), 32'd1);
    check_val("basic_countdown", 32'(cd_a), 32'd4);
    wait_a_done("basic_done");
    check_song("basic", t0, 4, -1);
    n_before = pa_cyc.size();
    repeat (6) step();
    check_val("done_quiet", 32'(pa_cyc.size()), 32'(n_before));

    // Period clamp: 0 behaves as 2; also a restart from DONE.
    pa_cyc.delete();
    pa_val.delete();
    do_start(24'd0, 1'b0, t0);
    check_val("restart_countdown", 32'(cd_a), 32'd4);
    check_val("restart_beat_count", 32'(bc_a), 32'd0);
    check_val("restart_done_clr", 32'(done_a), 32'd0);
    wait_a_done("clamp_done");
    check_song("clamp", t0, 2, -1);

    // Pause during the second PLAY beat, hold 37 cycles, resume.
    pa_cyc.delete();
    pa_val.delete();
    do_start(24'd4, 1'b0, t0);
    n = 0;
    while (pa_val.size() < 6 && n < 500) begin
      step();
      n++;
    end
    check_val("pause_reach_row2", 32'(pa_val.size()), 32'd6);
    step();
    pause_toggle = 1'b1;
    step();
    pause_toggle = 1'b0;
    check_val("pause_state", 32'(state_a), 32'd3);
    n_before = pa_cyc.size();
    repeat (37) step();
    check_val("pause_held_state", 32'(state_a), 32'd3);
    check_val("pause_no_pulse", 32'(pa_cyc.size()), 32'(n_before));
    pause_toggle = 1'b1;
    step();
    pause_toggle = 1'b0;
    t_res = cyc;
    check_val("resume_state", 32'(state_a), 32'd2);
    // Divider was 2 when paused: one more count, then the tick edge.
    start = 1'b1;
    step();
    start = 1'b0;
    check_val("start_in_play_ignored", 32'(state_a), 32'd2);
    check_val("start_in_play_countdown", 32'(cd_a), 32'd0);
    wait_a_done("pause_done");
    if (pa_cyc.size() > 6) check_val("resume_gap", 32'(pa_cyc[6] - t_res), 32'd2);
    else check_val("resume_pulse_seen", 32'(pa_cyc.size()), 32'd7);
    check_song("pause", t0, 4, 5);

    // No end flag on a 3-bit ROM; start+pause together in DONE.
    n = 0;
    while (!(done_a && done_b) && n < 1000) begin
      step();
      n++;
    end
    check_val("both_done", 32'(done_a && done_b), 32'd1);
    pb_val.delete();
    do_start(24'd3, 1'b1, t0);
    check_val("start_wins_a", 32'(state_a), 32'd1);
    check_val("start_wins_b", 32'(state_b), 32'd1);
    n = 0;
    while (state_b != 3'd4 && n < 500) begin
      step();
      n++;
    end
    check_val("b_drain_entry", 32'(state_b), 32'd4);
    check_val("b_npulse", 32'(pb_val.size()), 32'd12);
    bad = 0;
    for (int i = 0; i < pb_val.size() && i < 12; i++)
      if (pb_val[i] !== exp_b[i]) bad++;
    check_val("b_bad_rows", 32'(bad), 32'd0);
    check_val("b_rom_addr_top", 32'(ifb.rom_addr), 32'd7);
    check_val("b_beat_count_sat", 32'(bc_b), 32'd7);
    repeat (7) step();
    check_val("b_drain_state", 32'(state_b), 32'd4);
    check_val("b_no_wrap", 32'(ifb.rom_addr), 32'd7);
    check_val("b_drain_pulses", 32'(pb_val.size()), 32'd14);
    reset = 1'b1;
    step();
    check_val("b_reset_state", 32'(state_b), 32'd0);
    check_val("b_reset_step_en", 32'(ifb.step_en), 32'd0);
    check_val("b_reset_rom_addr", 32'(ifb.rom_addr), 32'd0);
    check_val("a_reset_state", 32'(state_a), 32'd0);
    reset = 1'b0;
    repeat (10) step();
    check_val("b_after_reset_quiet", 32'(pb_val.size()), 32'd14);
    check_val("no_double_step_en", 32'(dbl_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/beat_sequencer.md
Name: beat_sequencer

Overview:
- Game-flow scheduler for the step datapath.
- Generates the one-cycle beat pulse (step_en) from a programmable period and fetches step patterns from a song ROM.
- Feeds those patterns into the step shift register, one row per beat.
- Sequences the game through idle, countdown, play, pause, drain and done, so the scoring and display blocks see a clean song start and end.

Parameters:
- ADDR_W, 8, song ROM address width.
- DIV_W, 24, width of the beat period / divider counter.
- COUNTDOWN_BEATS, 4, blank beats emitted before the first song row.
- DRAIN_BEATS, 8, blank beats emitted after the last song row so it scrolls off the 8-row display.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle pulse; begins a song from IDLE or DONE.
- pause_toggle  in  1  single-cycle pulse; enters or leaves PAUSE.
- beat_period  in  DIV_W  clocks per beat; sampled only when start is accepted.
- rom_addr  out  ADDR_W  song ROM address.
- rom_data  in  5  {end_flag, step[3:0]}; valid 1 cycle after rom_addr.
- step_out  out  4  step row for the shift register.
- step_en  out  1  one-cycle beat pulse; shift register loads step_out.
- state  out  3  IDLE=0, COUNTDOWN=1, PLAY=2, PAUSE=3, DRAIN=4, DONE=5.
- countdown  out  3  remaining countdown beats (display use).
- beat_count  out  ADDR_W  song rows emitted; saturates at all-ones.
- done  out  1  high while in DONE.

Behaviour:
- Reset: state=IDLE; all outputs 0, including rom_addr, step_out, step_en, countdown, beat_count and done. Reset mid-song aborts immediately; no pending step_en survives.
- All outputs are registered.
- Period latch: on an accepted start, P = max(beat_period, 2). Values 0 and 1 are forced to 2.
- Start handling:
  - start is accepted only in IDLE or DONE; otherwise it is ignored.
  - On accept: divider=0, countdown=COUNTDOWN_BEATS, beat_count=0, rom_addr=0, step_out=0, done=0; go to COUNTDOWN.
- Divider:
  - Counts 0..P-1 in COUNTDOWN, PLAY and DRAIN; held in PAUSE.
  - A tick occurs when divider==P-1; the divider then wraps to 0.
  - step_en is asserted the cycle after a tick, with step_out already updated.
  - The first step_en falls exactly P cycles after the start-accept cycle; successive step_en pulses are exactly P cycles apart, excluding paused cycles.
- ROM prefetch:
  - rom_addr is presented continuously.
  - rom_data is captured into next_word one cycle after any rom_addr change.
  - P>=2 guarantees next_word is valid before the next tick.
- COUNTDOWN, on each tick:
  - step_out=0, step_en pulse, countdown decrements.
  - On the tick where countdown==1, countdown becomes 0 and the state moves to PLAY.
- PLAY, on each tick:
  - step_out=next_word[3:0], step_en pulse, beat_count+1 (saturating).
  - If next_word[4]==1, or rom_addr==all-ones: go to DRAIN with drain counter=DRAIN_BEATS.
  - Otherwise rom_addr+1. There is no address wrap.
- DRAIN, on each tick:
  - step_out=0, step_en pulse, drain counter decrements.
  - After DRAIN_BEATS pulses, go to DONE.
- DONE: done=1, step_en=0; step_out holds 0. Wait for start.
- PAUSE:
  - pause_toggle in COUNTDOWN, PLAY or DRAIN saves the state and enters PAUSE.
  - A second pause_toggle returns to the saved state.
  - While paused: divider, countdown, rom_addr and beat_count are frozen; step_en=0; step_out holds.
  - pause_toggle in IDLE or DONE is ignored.
- Simultaneous events:
  - start and pause_toggle in the same cycle in IDLE/DONE: start wins, pause is ignored.
  - pause_toggle in a tick cycle: the tick's effects (step_out/step_en, counter updates, state transition) complete first, then PAUSE is entered. The saved state is the post-tick state.
- step_en is never high for two consecutive cycles.

Test Plan:
- Reset then idle: with no start, hold for 100 cycles -> state=0 and step_en never high; every output is 0.
- Basic song:
  - Setup: P=4; ROM[0]=0x01, ROM[1]=0x02, ROM[2]=0x14; start.
  - Timing: step_en pulses every 4 cycles, first pulse 4 cycles after start.
  - Pulse sequence: 4 pulses with step_out=0; then 0x1, 0x2, 0x4; then 8 pulses with step_out=0.
  - End state: done=1, beat_count=3.
- Period clamp: beat_period=0 -> step_en every 2 cycles; song content identical to the basic-song case.
- Pause:
  - Stimulus: pause_toggle during the second PLAY beat, wait 37 cycles, pause_toggle again.
  - No step_en while paused; the next pulse arrives exactly the remaining divider count after resume; the row sequence is unchanged.
- Start while running: start pulse during PLAY is ignored, no restart; start in DONE restarts with countdown=4 and beat_count=0.
- No end flag:
  - Stimulus: ROM with no end flag and ADDR_W=3.
  - The 8th row (addr 7) is emitted, then DRAIN; rom_addr stays 7 with no wrap.
  - Reset mid-DRAIN forces state=0 and step_en=0 from the next cycle.
